// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the KGP mini-RISC datapath.
// Steps FETCH->DECODE->EXEC->MEM->WB and drives the datapath control bundle.
module multicycle_ctrl_fsm #(
  parameter int OPC_W       = 6,
  parameter int FUNC_W      = 6,
  parameter int ALU_OP_W    = 4,
  parameter int BR_OP_W     = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                dmem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          reg_write,
  output logic                imm_mux_ctrl,
  output logic                alu_mux_ctrl,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                dmem_enable,
  output logic                dmem_write_enable,
  output logic [1:0]          reg_write_mux_ctrl,
  output logic [BR_OP_W-1:0]  br_op,
  output logic                halt,
  output logic                fault,
  output logic [2:0]          state_out,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [OPC_W-1:0] OP_RALU = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_IALU = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_HALT = '1;

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t              r_state;
  state_t              w_next;
  logic [OPC_W-1:0]    r_opcode;
  logic [FUNC_W-1:0]   r_func;
  logic [TW-1:0]       r_tcnt;
  logic [CNT_W-1:0]    r_retired;

  logic w_is_alu, w_is_ialu, w_is_lw, w_is_sw, w_is_mem, w_is_br, w_is_halt, w_legal;
  logic [ALU_OP_W-1:0] w_ex_alu_op;
  logic w_unused;

  assign w_is_ialu   = (r_opcode == OP_IALU);
  assign w_is_alu    = (r_opcode == OP_RALU) || w_is_ialu;
  assign w_is_lw     = (r_opcode == OP_LW);
  assign w_is_sw     = (r_opcode == OP_SW);
  assign w_is_mem    = w_is_lw || w_is_sw;
  assign w_is_br     = (r_opcode == OP_BR);
  assign w_is_halt   = (r_opcode == OP_HALT);
  assign w_legal     = w_is_alu || w_is_mem || w_is_br || w_is_halt;
  assign w_ex_alu_op = w_is_alu ? r_func[ALU_OP_W-1:0] : '0;
  assign w_unused    = ^r_func;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_func    <= '0;
      r_tcnt    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && instr_valid) begin
        r_opcode <= opcode;
        r_func   <= func;
      end
      // Counts ready=0 cycles spent in MEM; clears whenever MEM is left.
      if (r_state == S_MEM && w_next == S_MEM) r_tcnt <= r_tcnt + 1'b1;
      else                                      r_tcnt <= '0;
      if (pc_write) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next             = r_state;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    reg_write          = 2'b00;
    imm_mux_ctrl       = 1'b0;
    alu_mux_ctrl       = 1'b0;
    alu_op             = '0;
    dmem_enable        = 1'b0;
    dmem_write_enable  = 1'b0;
    reg_write_mux_ctrl = 2'b00;
    br_op              = '0;
    halt               = 1'b0;
    fault              = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write = instr_valid;
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_halt)     w_next = S_HALT;
        else if (!w_legal) w_next = S_FAULT;
        else               w_next = S_EXEC;
      end
      S_EXEC: begin
        alu_op       = w_ex_alu_op;
        alu_mux_ctrl = w_is_ialu || w_is_mem;
        imm_mux_ctrl = w_is_mem;
        if (w_is_br) begin
          br_op    = r_func[BR_OP_W-1:0];
          pc_write = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_mem) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        alu_op            = w_ex_alu_op;
        alu_mux_ctrl      = 1'b1;
        imm_mux_ctrl      = 1'b1;
        dmem_enable       = 1'b1;
        dmem_write_enable = w_is_sw;
        // Ready on the final allowed cycle takes priority over the timeout.
        if (dmem_ready) begin
          if (w_is_sw) begin
            pc_write = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (MEM_TIMEOUT != 0 && r_tcnt == TCNT_LAST) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        alu_op             = w_ex_alu_op;
        alu_mux_ctrl       = w_is_ialu || w_is_mem;
        imm_mux_ctrl       = w_is_mem;
        reg_write          = w_is_lw ? 2'b10 : 2'b01;
        reg_write_mux_ctrl = w_is_lw ? 2'b01 : 2'b10;
        pc_write           = 1'b1;
        w_next             = S_FETCH;
      end
      S_HALT:  halt  = 1'b1;
      S_FAULT: fault = 1'b1;
      default: w_next = S_FAULT;
    endcase
  end

  assign state_out = r_state;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-instruction expected cycle
// sequences are built from the instruction class and checked every cycle.
module tb_multicycle_ctrl_fsm;
  localparam int CW = 4;
  localparam int W  = CW + 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       dmem_ready;
  logic       ir_write, pc_write, imm_mux_ctrl, alu_mux_ctrl;
  logic       dmem_enable, dmem_write_enable, halt, fault;
  logic [1:0] reg_write, reg_write_mux_ctrl;
  logic [3:0] alu_op;
  logic [4:0] br_op;
  logic [2:0] state_out;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  e_c;
  logic [CW-1:0] m_retired;
  logic [W-1:0]  got;

  assign got = {state_out, ir_write, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl,
                alu_op, dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op,
                halt, fault, retired};

  multicycle_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .func(func),
    .dmem_ready(dmem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .imm_mux_ctrl(imm_mux_ctrl), .alu_mux_ctrl(alu_mux_ctrl),
    .alu_op(alu_op), .dmem_enable(dmem_enable), .dmem_write_enable(dmem_write_enable),
    .reg_write_mux_ctrl(reg_write_mux_ctrl), .br_op(br_op), .halt(halt), .fault(fault),
    .state_out(state_out), .retired(retired)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard compare: one expected vector per cycle, sampled at negedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_c = exp_q.pop_front();
      total++;
      if (got !== e_c) begin
        bad++;
        $display("FAIL cyc t=%0t got=%h exp=%h", $time, got, e_c);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ev(input int st, input bit irw, input bit pcw, input int rw,
                                      input bit imm, input bit am, input int aop, input bit den,
                                      input bit dwe, input int rwm, input int br,
                                      input bit h, input bit f);
    return {3'(st), irw, pcw, 2'(rw), imm, am, 4'(aop), den, dwe, 2'(rwm), 5'(br), h, f, m_retired};
  endfunction

  // negative argument = don't care, drive random
  task automatic cycle(input int v, input int o, input int f, input int r, input logic [W-1:0] e);
    instr_valid = (v < 0) ? 1'($urandom_range(0, 1)) : 1'(v);
    opcode      = (o < 0) ? 6'($urandom_range(0, 63)) : 6'(o);
    func        = (f < 0) ? 6'($urandom_range(0, 63)) : 6'(f);
    dmem_ready  = (r < 0) ? 1'($urandom_range(0, 1)) : 1'(r);
    exp_q.push_back(e);
    if (e[W-5]) m_retired = m_retired + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic sink(input int st, input bit h, input bit f);
    for (int i = 0; i < 3; i++) cycle(-1, -1, -1, -1, ev(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h, f));
  endtask

  // waits = MEM cycles with ready low before ready; >= 15 means timeout
  task automatic run_instr(input int opc, input int fn, input int waits);
    bit alu, ialu, lw, sw, mem, br, hlt, legal;
    int aop, brv;
    alu   = (opc == 0) || (opc == 1);
    ialu  = (opc == 1);
    lw    = (opc == 2);
    sw    = (opc == 3);
    mem   = lw || sw;
    br    = (opc == 4);
    hlt   = (opc == 63);
    legal = alu || mem || br || hlt;
    aop   = alu ? (fn % 16) : 0;
    brv   = br ? (fn % 32) : 0;
    cycle(1, opc, fn, -1, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(-1, -1, -1, -1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (hlt) begin sink(5, 1, 0); return; end
    if (!legal) begin sink(6, 0, 1); return; end
    cycle(-1, -1, -1, -1, ev(2, 0, br, 0, mem, ialu || mem, aop, 0, 0, 0, brv, 0, 0));
    if (br) return;
    if (mem) begin
      for (int i = 0; i < waits && i < 15; i++)
        cycle(-1, -1, -1, 0, ev(3, 0, 0, 0, 1, 1, 0, 1, sw, 0, 0, 0, 0));
      if (waits >= 15) begin sink(6, 0, 1); return; end
      cycle(-1, -1, -1, 1, ev(3, 0, sw, 0, 1, 1, 0, 1, sw, 0, 0, 0, 0));
      if (sw) return;
    end
    cycle(-1, -1, -1, -1, ev(4, 0, 1, lw ? 2 : 1, mem, ialu || mem, aop, 0, 0, lw ? 1 : 2, 0, 0, 0));
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_vec", 32'(got), 32'd0);
    m_retired = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // cycles from FETCH with valid until FETCH again, measured on the DUT
  task automatic measure(input string name, input int opc, input int fn, input int lat);
    int n;
    n = 0;
    instr_valid = 1'b1;
    opcode = 6'(opc);
    func = 6'(fn);
    dmem_ready = 1'b1;
    do begin
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      n++;
    end while (state_out != 3'd0 && n < 20);
    check(name, 32'(n), 32'(lat));
    m_retired = m_retired + 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = '0;
    func = '0;
    dmem_ready = 1'b0;
    m_retired = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(got), 32'd0);
    rst = 1'b1;
    cycle(0, -1, -1, -1, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    run_instr(0, 3, 0);
    check("ret_xor", 32'(retired), 32'd1);
    run_instr(1, 0, 0);
    check("ret_addi", 32'(retired), 32'd2);
    run_instr(2, 5, 3);
    run_instr(3, 0, 0);
    check("ret_lwsw", 32'(retired), 32'd4);
    run_instr(4, 6'h2A, 0);
    run_instr(0, 6'h3C, 0);
    check("ret_br_alu", 32'(retired), 32'd6);

    measure("lat_br", 4, 1, 3);
    measure("lat_alu", 0, 2, 4);
    measure("lat_sw", 3, 0, 4);
    measure("lat_lw", 2, 0, 5);
    check("ret_lat", 32'(retired), 32'd10);

    run_instr(3, 0, 14);
    check("ret_late_ready", 32'(retired), 32'd11);

    // reset while an LW sits in MEM
    cycle(1, 2, 0, -1, ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(-1, -1, -1, -1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(-1, -1, -1, -1, ev(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    cycle(-1, -1, -1, 0, ev(3, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    instr_valid = 1'b0;
    dmem_ready = 1'b0;
    #2;
    check("mid_mem_den", 32'(dmem_enable), 32'd1);
    check("mid_mem_state", 32'(state_out), 32'd3);
    do_reset();
    run_instr(0, 3, 0);
    check("ret_after_rst", 32'(retired), 32'd1);

    run_instr(3, 0, 15);
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_ret", 32'(retired), 32'd1);
    do_reset();

    run_instr(7, 0, 0);
    check("illegal_fault", 32'(fault), 32'd1);
    do_reset();
    run_instr(62, 0, 0);
    do_reset();
    run_instr(63, 0, 0);
    check("halt_flag", 32'(halt), 32'd1);
    do_reset();

    for (int i = 0; i < 15; i++) run_instr(4, 1, 0);
    check("ret_max", 32'(retired), 32'd15);
    run_instr(0, 1, 0);
    check("ret_wrap", 32'(retired), 32'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

endmodule
